// File: rtl/dbf_scan_seq.sv
// Scan-line sequencer for the digital beamformer: LUT load, transmit window, receive window.
// Optional macro DBF_LINE_CNT_EN adds a 16-bit completed-line counter output.
module dbf_scan_seq #(
    parameter int unsigned ADDR_WD   = 11,
    parameter int unsigned LUT_DEPTH = 2048,
    parameter int unsigned TX_LEN    = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_trig,
    input  logic               lut_load_req,
    input  logic               abort,
    output logic               tx_en,
    output logic               start,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic               dbf_lut_we,
    output logic               lut_load_ack,
    output logic               line_done,
    output logic               trig_drop,
    output logic               busy
`ifdef DBF_LINE_CNT_EN
    ,
    output logic [15:0]        line_cnt
`endif
);

    // One phase counter serves LOAD, TX and RX, so it must span both LUT and TX lengths.
    localparam int unsigned TX_WD  = (TX_LEN > 1) ? $clog2(TX_LEN) : 1;
    localparam int unsigned CNT_WD = (ADDR_WD > TX_WD) ? ADDR_WD : TX_WD;

    localparam logic [CNT_WD-1:0] LUT_LAST = CNT_WD'(LUT_DEPTH - 1);
    localparam logic [CNT_WD-1:0] TX_LAST  = CNT_WD'(TX_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StTx,
        StRx,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;

    logic                tx_en_q, tx_en_d;
    logic                start_q, start_d;
    logic                we_q, we_d;
    logic [ADDR_WD-1:0]  addr_q, addr_d;
    logic                ack_q, ack_d;
    logic                done_q, done_d;
    logic                drop_q, drop_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_WD'(1);

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (lut_load_req) begin
                    state_d = StLoad;
                end else if (line_trig) begin
                    state_d = StTx;
                end
            end
            StLoad: begin
                if (cnt_q == LUT_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StTx: begin
                if (cnt_q == TX_LAST) begin
                    state_d = StRx;
                    cnt_d   = '0;
                end
            end
            StRx: begin
                if (cnt_q == LUT_LAST) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        tx_en_d = (state_d == StTx);
        start_d = (state_d == StRx);
        we_d    = (state_d == StLoad);
        addr_d  = '0;
        if ((state_d == StLoad) || (state_d == StRx)) begin
            addr_d = cnt_d[ADDR_WD-1:0];
        end
        ack_d   = (state_q == StLoad) && (state_d == StIdle) && !abort;
        done_d  = (state_d == StDone);
        drop_d  = line_trig && ((state_q != StIdle) || lut_load_req || abort);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tx_en_q <= 1'b0;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_en_q <= tx_en_d;
            start_q <= start_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_en        = tx_en_q;
    assign start        = start_q;
    assign dbf_lut_we   = we_q;
    assign dbf_lut_addr = addr_q;
    assign lut_load_ack = ack_q;
    assign line_done    = done_q;
    assign trig_drop    = drop_q;
    assign busy         = busy_q;

`ifdef DBF_LINE_CNT_EN
    logic [15:0] line_cnt_q;

    // Counts alongside the line_done flop; abort only suppresses done, never touches the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
        end else if (done_d) begin
            line_cnt_q <= line_cnt_q + 16'd1;
        end
    end

    assign line_cnt = line_cnt_q;
`endif

endmodule

// File: tb/tb_dbf_scan_seq.sv
// Self-checking bench for dbf_scan_seq: directed scan/load/abort/reset scenarios plus random
// traffic, all compared cycle by cycle against a phase/offset reference model.
module tb_dbf_scan_seq;

    localparam int ADDR_WD   = 11;
    localparam int LUT_DEPTH = 2048;
    localparam int TX_LEN    = 64;
    localparam int DONE_OFS  = TX_LEN + LUT_DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, line_trig, lut_load_req, abort;
    logic               tx_en, start, dbf_lut_we, lut_load_ack, line_done, trig_drop, busy;
    logic [ADDR_WD-1:0] dbf_lut_addr;
`ifdef DBF_LINE_CNT_EN
    logic [15:0]        line_cnt;
`endif

    dbf_scan_seq #(
        .ADDR_WD  (ADDR_WD),
        .LUT_DEPTH(LUT_DEPTH),
        .TX_LEN   (TX_LEN)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_trig   (line_trig),
        .lut_load_req(lut_load_req),
        .abort       (abort),
        .tx_en       (tx_en),
        .start       (start),
        .dbf_lut_addr(dbf_lut_addr),
        .dbf_lut_we  (dbf_lut_we),
        .lut_load_ack(lut_load_ack),
        .line_done   (line_done),
        .trig_drop   (trig_drop),
        .busy        (busy)
`ifdef DBF_LINE_CNT_EN
        ,
        .line_cnt    (line_cnt)
`endif
    );

`ifdef DBF_LINE_CNT_EN
    logic       s_rst_n, s_trig;
    logic       s_tx_en, s_start, s_we, s_ack, s_done, s_drop, s_busy;
    logic [1:0] s_addr;
    logic [15:0] s_line_cnt;

    dbf_scan_seq #(
        .ADDR_WD  (2),
        .LUT_DEPTH(4),
        .TX_LEN   (1)
    ) u_small (
        .clk         (clk),
        .rst_n       (s_rst_n),
        .line_trig   (s_trig),
        .lut_load_req(1'b0),
        .abort       (1'b0),
        .tx_en       (s_tx_en),
        .start       (s_start),
        .dbf_lut_addr(s_addr),
        .dbf_lut_we  (s_we),
        .lut_load_ack(s_ack),
        .line_done   (s_done),
        .trig_drop   (s_drop),
        .busy        (s_busy),
        .line_cnt    (s_line_cnt)
    );
`endif

    int n_vec, n_err;
    int cyc, base;

    // Reference model: which phase is running (0 idle, 1 load, 2 line) and the offset into it.
    int m_mode, m_t, m_ack, m_drop, m_cnt;

    int f_tx, l_tx, n_tx, f_st, l_st, n_st, f_we, l_we, n_we;
    int at_done, n_done, at_ack, n_ack, n_drop;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_mode = 0;
            m_t    = 0;
            m_ack  = 0;
            m_drop = 0;
            m_cnt  = 0;
        end else begin
            m_drop = (line_trig && (m_mode != 0 || lut_load_req || abort)) ? 1 : 0;
            m_ack  = 0;
            if (abort) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (lut_load_req) begin
                    m_mode = 1;
                    m_t    = 0;
                end else if (line_trig) begin
                    m_mode = 2;
                    m_t    = 0;
                end
            end else begin
                m_t++;
                if (m_mode == 1 && m_t == LUT_DEPTH) begin
                    m_mode = 0;
                    m_ack  = 1;
                end else if (m_mode == 2 && m_t == DONE_OFS + 1) begin
                    m_mode = 0;
                end
            end
            if (m_mode == 2 && m_t == DONE_OFS) m_cnt = (m_cnt + 1) % 65536;
        end
    endtask

    task automatic compare_outputs();
        int e_tx, e_st, e_we, e_addr, e_done;
        e_tx   = (m_mode == 2 && m_t < TX_LEN) ? 1 : 0;
        e_st   = (m_mode == 2 && m_t >= TX_LEN && m_t < DONE_OFS) ? 1 : 0;
        e_we   = (m_mode == 1) ? 1 : 0;
        e_addr = (m_mode == 1) ? m_t : (e_st == 1 ? m_t - TX_LEN : 0);
        e_done = (m_mode == 2 && m_t == DONE_OFS) ? 1 : 0;
        check("tx_en", int'(tx_en), e_tx);
        check("start", int'(start), e_st);
        check("dbf_lut_we", int'(dbf_lut_we), e_we);
        check("dbf_lut_addr", int'(dbf_lut_addr), e_addr);
        check("line_done", int'(line_done), e_done);
        check("lut_load_ack", int'(lut_load_ack), m_ack);
        check("trig_drop", int'(trig_drop), m_drop);
        check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
        check("mutex", (int'(tx_en) + int'(start) + int'(dbf_lut_we) <= 1) ? 1 : 0, 1);
`ifdef DBF_LINE_CNT_EN
        check("line_cnt", int'(line_cnt), m_cnt);
`endif
    endtask

    task automatic track();
        int rel;
        rel = cyc - base;
        if (tx_en) begin
            if (f_tx < 0) f_tx = rel;
            l_tx = rel;
            n_tx++;
        end
        if (start) begin
            if (f_st < 0) f_st = rel;
            l_st = rel;
            n_st++;
        end
        if (dbf_lut_we) begin
            if (f_we < 0) f_we = rel;
            l_we = rel;
            n_we++;
        end
        if (line_done) begin
            at_done = rel;
            n_done++;
        end
        if (lut_load_ack) begin
            at_ack = rel;
            n_ack++;
        end
        if (trig_drop) n_drop++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        compare_outputs();
        track();
    endtask

    task automatic begin_scn();
        base = cyc;
        f_tx = -1; l_tx = -1; n_tx = 0;
        f_st = -1; l_st = -1; n_st = 0;
        f_we = -1; l_we = -1; n_we = 0;
        at_done = -1; n_done = 0; at_ack = -1; n_ack = 0; n_drop = 0;
    endtask

    task automatic idle_inputs();
        rst_n        = 1'b1;
        line_trig    = 1'b0;
        lut_load_req = 1'b0;
        abort        = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        m_mode = 0; m_t = 0; m_ack = 0; m_drop = 0; m_cnt = 0;
`ifdef DBF_LINE_CNT_EN
        s_rst_n = 1'b0;
        s_trig  = 1'b0;
`endif
        // Reset with a trig held high: nothing may happen, not even a drop pulse.
        begin_scn();
        rst_n = 1'b0; line_trig = 1'b1; lut_load_req = 1'b0; abort = 1'b0;
        repeat (3) step();
        check("rst_no_drop", n_drop, 0);
        check("rst_busy", int'(busy), 0);
`ifdef DBF_LINE_CNT_EN
        s_rst_n = 1'b1;
`endif

        // Scan line triggered at cycle 10.
        begin_scn();
        while (cyc - base < 2130) begin
            idle_inputs();
            if (cyc - base == 10) line_trig = 1'b1;
            step();
        end
        check("s1_tx_first", f_tx, 11);
        check("s1_tx_last", l_tx, 74);
        check("s1_rx_first", f_st, 75);
        check("s1_rx_last", l_st, 2122);
        check("s1_done_at", at_done, 2123);
        check("s1_done_cnt", n_done, 1);

        // LUT load requested at cycle 5, released mid-load.
        begin_scn();
        while (cyc - base < 2060) begin
            idle_inputs();
            if (cyc - base == 5) lut_load_req = 1'b1;
            step();
        end
        check("s2_we_first", f_we, 6);
        check("s2_we_last", l_we, 2053);
        check("s2_we_cnt", n_we, 2048);
        check("s2_ack_at", at_ack, 2054);
        check("s2_ack_cnt", n_ack, 1);
        check("s2_no_tx_rx", n_tx + n_st, 0);

        // Trig and load together in IDLE: load wins, trig dropped.
        begin_scn();
        while (cyc - base < 2060) begin
            idle_inputs();
            if (cyc - base == 2) begin
                line_trig    = 1'b1;
                lut_load_req = 1'b1;
            end
            step();
        end
        check("s3_we_first", f_we, 3);
        check("s3_ack_at", at_ack, 2051);
        check("s3_drop_cnt", n_drop, 1);
        check("s3_no_tx", n_tx, 0);

        // Second trig while RX is at address 100.
        begin_scn();
        while (cyc - base < 2120) begin
            idle_inputs();
            if (cyc - base == 0) line_trig = 1'b1;
            if (cyc - base == 165) begin
                check("s4_addr100", int'(dbf_lut_addr), 100);
                line_trig = 1'b1;
            end
            step();
        end
        check("s4_drop_cnt", n_drop, 1);
        check("s4_rx_last", l_st, 2112);
        check("s4_done_at", at_done, 2113);
        check("s4_done_cnt", n_done, 1);

        // Abort at TX cycle 30, then a fresh line.
        begin_scn();
        while (cyc - base < 2160) begin
            idle_inputs();
            if (cyc - base == 0) line_trig = 1'b1;
            if (cyc - base == 30) abort = 1'b1;
            if (cyc - base == 31) check("s5_busy_after_abort", int'(busy), 0);
            if (cyc - base == 40) line_trig = 1'b1;
            step();
        end
        check("s5_tx_cnt", n_tx, 30 + TX_LEN);
        check("s5_done_cnt", n_done, 1);
        check("s5_done_at", at_done, 40 + 1 + TX_LEN + LUT_DEPTH);

        // Reset mid-LOAD with a trig during reset.
        begin_scn();
        while (cyc - base < 2100) begin
            idle_inputs();
            if (cyc - base == 0) lut_load_req = 1'b1;
            if (cyc - base == 500 || cyc - base == 501) begin
                rst_n     = 1'b0;
                line_trig = 1'b1;
            end
            step();
        end
        check("s6_we_last", l_we, 500);
        check("s6_no_ack", n_ack, 0);
        check("s6_no_drop", n_drop, 0);

        // Reset mid-RX.
        begin_scn();
        while (cyc - base < 2200) begin
            idle_inputs();
            if (cyc - base == 0) line_trig = 1'b1;
            if (cyc - base == 1000) rst_n = 1'b0;
            step();
        end
        check("s7_rx_last", l_st, 1000);
        check("s7_no_done", n_done, 0);

        // Random traffic against the model.
        begin_scn();
        repeat (20000) begin
            rst_n        = ($urandom_range(5999) != 0);
            line_trig    = ($urandom_range(149) == 0);
            lut_load_req = ($urandom_range(399) == 0);
            abort        = ($urandom_range(2499) == 0);
            step();
        end
        idle_inputs();

`ifdef DBF_LINE_CNT_EN
        // Small instance: three short lines, then reset clears the count.
        begin
            int s_dones;
            s_dones = 0;
            for (int i = 0; i < 30; i++) begin
                s_trig = (i % 10 == 0);
                step();
                if (s_done) s_dones++;
            end
            s_trig = 1'b0;
            check("small_done_cnt", s_dones, 3);
            check("small_line_cnt", int'(s_line_cnt), 3);
            s_rst_n = 1'b0;
            step();
            s_rst_n = 1'b1;
            check("small_line_cnt_rst", int'(s_line_cnt), 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
